// File: rtl/add_pkg.sv
// add_pkg: shared widths and types for the add16 adder slice
package add_pkg;
  localparam int WIDTH_DEFAULT = 16;
  localparam int GROUP_DEFAULT = 4;
  typedef logic [15:0] word_t;
endpackage

// File: rtl/add16_if.sv
// add16_if: operand/result bundle between a datapath client and the adder
interface add16_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic             C;
  modport master (output A, B, input S, C);
  modport slave  (input A, B, output S, C);
endinterface

// File: rtl/add16_cla_group.sv
// cla_group: one carry-lookahead group producing its sum slice and group G/P
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] i_a,
  input  logic [GROUP-1:0] i_b,
  input  logic             i_ci,
  output logic [GROUP-1:0] o_sum,
  output logic             o_g,
  output logic             o_p
);
  logic [GROUP-1:0] w_g;
  logic [GROUP-1:0] w_p;
  logic [GROUP-1:0] w_c;
  logic [GROUP-1:0] w_gc;
  logic             w_t;
  logic             w_u;
  assign w_g   = i_a & i_b;
  assign w_p   = i_a ^ i_b;
  assign w_gc  = {w_g[GROUP-2:0], i_ci};
  assign o_p   = &w_p;
  assign o_sum = w_p ^ w_c;
  // carry into bit i as a sum of products over the generates (and carry-in) below it
  always_comb begin
    w_c = '0;
    w_t = 1'b0;
    for (int i = 0; i < GROUP; i++)
      for (int j = 0; j <= i; j++) begin
        w_t = w_gc[j];
        for (int k = j; k < i; k++) w_t = w_t & w_p[k];
        w_c[i] = w_c[i] | w_t;
      end
  end
  // group generate kept independent of carry-in so the second level sees no loop
  always_comb begin
    o_g = 1'b0;
    w_u = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      w_u = w_g[j];
      for (int k = j + 1; k < GROUP; k++) w_u = w_u & w_p[k];
      o_g = o_g | w_u;
    end
  end
endmodule

// File: rtl/add16.sv
// add16: registered unsigned adder with carry-out built from two-level lookahead
module add16
  import add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int GROUP = GROUP_DEFAULT
) (
  input logic   CLK,
  input logic   RST_N,
  add16_if.slave bus
);
  localparam int NG = WIDTH / GROUP;
  logic [NG-1:0]    w_gg;
  logic [NG-1:0]    w_gp;
  logic [NG:0]      w_gc;
  logic [NG:0]      w_cg;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic             w_t;
  generate
    for (genvar k = 0; k < NG; k++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .i_a  (bus.A[k*GROUP +: GROUP]),
        .i_b  (bus.B[k*GROUP +: GROUP]),
        .i_ci (w_cg[k]),
        .o_sum(w_sum[k*GROUP +: GROUP]),
        .o_g  (w_gg[k]),
        .o_p  (w_gp[k])
      );
    end
  endgenerate
  assign w_gc = {w_gg, 1'b0};
  // second-level lookahead: carry into group k from all lower group generates; carry-in is 0
  always_comb begin
    w_cg = '0;
    w_t  = 1'b0;
    for (int k = 1; k <= NG; k++)
      for (int j = 0; j <= k; j++) begin
        w_t = (j == k) ? 1'b0 : w_gc[j];
        for (int m = j; m < k; m++) w_t = w_t & w_gp[m];
        w_cg[k] = w_cg[k] | w_t | ((j == k - 1) ? w_gg[k-1] : 1'b0);
      end
  end
  // result registers; reset clears them at once and drops any in-flight sum
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s <= '0;
      r_c <= 1'b0;
    end else begin
      r_s <= w_sum;
      r_c <= w_cg[NG];
    end
  end
  assign bus.S = r_s;
  assign bus.C = r_c;
endmodule

// File: tb/tb_add16.sv
// tb_add16: scoreboard bench for the registered 16-bit lookahead adder
module tb_add16;
  import add_pkg::*;
  logic CLK;
  logic RST_N;
  int   total;
  int   bad;
  logic [16:0] sb[$];
  logic [16:0] exp;
  add16_if #(.WIDTH(16)) bus ();
  add16 #(.WIDTH(16), .GROUP(4)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic apply(input word_t a, input word_t b, input logic [16:0] e);
    @(negedge CLK);
    bus.A = a;
    bus.B = b;
    sb.push_back(e);
  endtask
  task automatic test_reset();
    bus.A = 16'hFFFF;
    bus.B = 16'hFFFF;
    RST_N = 1'b0;
    #2;
    total++;
    if ({bus.C, bus.S} !== 17'h0) begin
      bad++;
      $display("FAIL reset_init got=%h want=%h", {bus.C, bus.S}, 17'h0);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    total++;
    if ({bus.C, bus.S} !== 17'h1FFFE) begin
      bad++;
      $display("FAIL reset_pre got=%h want=%h", {bus.C, bus.S}, 17'h1FFFE);
    end
    @(negedge CLK);
    bus.A = 16'h1234;
    bus.B = 16'h4321;
    #2;
    RST_N = 1'b0;
    #1;
    total++;
    if ({bus.C, bus.S} !== 17'h0) begin
      bad++;
      $display("FAIL reset_async got=%h want=%h", {bus.C, bus.S}, 17'h0);
    end
    @(posedge CLK);
    #1;
    total++;
    if ({bus.C, bus.S} !== 17'h0) begin
      bad++;
      $display("FAIL reset_hold got=%h want=%h", {bus.C, bus.S}, 17'h0);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    total++;
    if ({bus.C, bus.S} !== 17'h05555) begin
      bad++;
      $display("FAIL reset_release got=%h want=%h", {bus.C, bus.S}, 17'h05555);
    end
  endtask
  task automatic test_latency();
    apply(16'h0001, 16'h0002, 17'h00003);
    #1;
    total++;
    if ({bus.C, bus.S} !== 17'h05555) begin
      bad++;
      $display("FAIL latency_early got=%h want=%h", {bus.C, bus.S}, 17'h05555);
    end
    @(posedge CLK);
    #1;
    exp = sb.pop_front();
    total++;
    if ({bus.C, bus.S} !== exp) begin
      bad++;
      $display("FAIL latency_first got=%h want=%h", {bus.C, bus.S}, exp);
    end
    apply(16'h0010, 16'h0020, 17'h00030);
    #1;
    total++;
    if ({bus.C, bus.S} !== 17'h00003) begin
      bad++;
      $display("FAIL latency_stable got=%h want=%h", {bus.C, bus.S}, 17'h00003);
    end
    @(posedge CLK);
    #1;
    exp = sb.pop_front();
    total++;
    if ({bus.C, bus.S} !== exp) begin
      bad++;
      $display("FAIL latency_second got=%h want=%h", {bus.C, bus.S}, exp);
    end
  endtask
  task automatic test_boundaries();
    word_t       ta[9] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h000F, 16'h00FF, 16'h0FFF, 16'h7FFF, 16'hF000};
    word_t       tb[9] = '{16'h0000, 16'hFFFF, 16'h0001, 16'h8000, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h1000};
    logic [16:0] te[9] = '{17'h00000, 17'h1FFFE, 17'h10000, 17'h10000, 17'h00010, 17'h00100, 17'h01000, 17'h08000, 17'h10000};
    for (int i = 0; i < 9; i++) begin
      apply(ta[i], tb[i], te[i]);
      @(posedge CLK);
      #1;
      exp = sb.pop_front();
      total++;
      if ({bus.C, bus.S} !== exp) begin
        bad++;
        $display("FAIL boundary_%0d a=%h b=%h got=%h want=%h", i, ta[i], tb[i], {bus.C, bus.S}, exp);
      end
    end
  endtask
  task automatic test_sweep();
    int   errs;
    word_t a;
    word_t b;
    errs = 0;
    for (int n = 0; n < 31024; n++) begin
      a = (n < 1024) ? 16'h0 : word_t'($urandom);
      b = (n < 1024) ? word_t'(n) : word_t'($urandom);
      apply(a, b, {1'b0, a} + {1'b0, b});
      @(posedge CLK);
      #1;
      exp = sb.pop_front();
      total++;
      if ({bus.C, bus.S} !== exp) begin
        bad++;
        errs++;
        if (errs <= 10) $display("FAIL sweep a=%h b=%h got=%h want=%h", a, b, {bus.C, bus.S}, exp);
      end
    end
  endtask
  task automatic test_back_to_back();
    apply(16'h0000, 16'h0000, 17'h00000);
    for (int n = 1; n < 16; n++) begin
      if (n[0]) apply(16'hFFFF, 16'hFFFF, 17'h1FFFE);
      else apply(16'h0000, 16'h0000, 17'h00000);
      #1;
      exp = sb.pop_front();
      total++;
      if ({bus.C, bus.S} !== exp) begin
        bad++;
        $display("FAIL back_to_back_%0d got=%h want=%h", n, {bus.C, bus.S}, exp);
      end
    end
    @(posedge CLK);
    #1;
    exp = sb.pop_front();
    total++;
    if ({bus.C, bus.S} !== exp) begin
      bad++;
      $display("FAIL back_to_back_last got=%h want=%h", {bus.C, bus.S}, exp);
    end
  endtask
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_latency();
    test_boundaries();
    test_back_to_back();
    test_sweep();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
